// File: rtl/linear_reorder_fifo.sv
// rtl/linear_reorder_fifo.sv - reorder buffer that drains linear base addresses in reservation order
// Optional block-done flush is compiled in with `define LINEAR_ROB_FLUSH_EN.
module linear_reorder_fifo #(
  parameter  int LBW   = 10,
  parameter  int DEPTH = 4,
  localparam int TBW   = $clog2(DEPTH),
  localparam int CBW   = $clog2(DEPTH + 1)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           alloc_rdy,
  output logic           alloc_ack,
  output logic [TBW-1:0] o_alloc_tag,
  input  logic           fill_dval,
  input  logic [TBW-1:0] i_fill_tag,
  input  logic [LBW-1:0] i_fill_linear,
  output logic           dst_rdy,
  input  logic           dst_ack,
  output logic [LBW-1:0] o_linear,
  output logic [CBW-1:0] o_count,
  output logic           o_full,
  output logic           o_empty,
  output logic           o_err
`ifdef LINEAR_ROB_FLUSH_EN
  ,
  input  logic           blkdone_dval
`endif
);

  // Storage is sized to the full tag space so any tag value indexes safely;
  // slots at or above DEPTH are never reserved and therefore never written.
  localparam int NS = 1 << TBW;
  localparam int PW = CBW + 1;
  localparam logic [TBW-1:0] LAST_TAG = TBW'(DEPTH - 1);
  localparam logic [CBW-1:0] DEPTH_C  = CBW'(DEPTH);

  logic [TBW-1:0] wptr_q, wptr_d;
  logic [TBW-1:0] rptr_q, rptr_d;
  logic [CBW-1:0] count_q, count_d;
  logic           err_q, err_d;
  logic [NS-1:0]  filled_q, filled_d;
  logic [LBW-1:0] linear_q [NS];

  logic           full, empty, flush, drain, head_filled;
  logic           tag_reserved, fill_ok, fill_err;
  logic [PW-1:0]  tag_off;

`ifdef LINEAR_ROB_FLUSH_EN
  assign flush = blkdone_dval;
`else
  assign flush = 1'b0;
`endif

  function automatic logic [TBW-1:0] next_tag(input logic [TBW-1:0] t);
    return (t == LAST_TAG) ? '0 : t + TBW'(1);
  endfunction

  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign head_filled = filled_q[rptr_q];

  assign alloc_ack   = alloc_rdy && !full && !flush;
  assign dst_rdy     = head_filled && !empty && !flush;
  assign drain       = dst_ack && dst_rdy;

  assign o_alloc_tag = wptr_q;
  assign o_linear    = linear_q[rptr_q];
  assign o_count     = count_q;
  assign o_full      = full;
  assign o_empty     = empty;
  assign o_err       = err_q;

  // A tag is reserved when its circular distance from rptr is below the count.
  always_comb begin
    tag_off = '0;
    if (i_fill_tag >= rptr_q) begin
      tag_off = PW'(i_fill_tag) - PW'(rptr_q);
    end else begin
      tag_off = PW'(i_fill_tag) + PW'(DEPTH) - PW'(rptr_q);
    end
  end

  assign tag_reserved = (PW'(i_fill_tag) < PW'(DEPTH)) && (tag_off < PW'(count_q));
  assign fill_ok      = fill_dval && tag_reserved;
  assign fill_err     = fill_dval && (!tag_reserved || filled_q[i_fill_tag]);

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    filled_d = filled_q;
    err_d    = err_q | fill_err | (dst_ack && !dst_rdy);

    if (alloc_ack) begin
      wptr_d = next_tag(wptr_q);
    end
    if (fill_ok) begin
      filled_d[i_fill_tag] = 1'b1;
    end
    // Clearing after the set makes a same-cycle fill to the draining head end cleared.
    if (drain) begin
      filled_d[rptr_q] = 1'b0;
      rptr_d           = next_tag(rptr_q);
    end

    case ({alloc_ack, drain})
      2'b10:   count_d = count_q + CBW'(1);
      2'b01:   count_d = count_q - CBW'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      wptr_d   = '0;
      rptr_d   = '0;
      count_d  = '0;
      filled_d = '0;
      err_d    = err_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      filled_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      filled_q <= filled_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NS; i++) linear_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NS; i++) linear_q[i] <= '0;
    end else if (fill_ok) begin
      linear_q[i_fill_tag] <= i_fill_linear;
    end
  end

endmodule

// File: doc/linear_reorder_fifo.md
LINEAR_REORDER_FIFO -- requirements
Module: linear_reorder_fifo

Interface
REQ-001 SHALL have parameter LBW, default 10: width of a local linear base address.
REQ-002 SHALL have parameter DEPTH, default 4, legal range 2..16: number of slots; DEPTH need not be a power of two.
REQ-003 SHALL derive TBW = $clog2(DEPTH) and CBW = $clog2(DEPTH+1).
REQ-004 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 i_rst  input  1  reset; asynchronous and active-high.
REQ-006 alloc_rdy  input  1  a chunk requests a slot reservation.
REQ-007 alloc_ack  output  1  reservation accepted this cycle.
REQ-008 o_alloc_tag  output  TBW  slot tag granted; valid while alloc_rdy.
REQ-009 fill_dval  input  1  a completed linear is delivered this cycle.
REQ-010 i_fill_tag  input  TBW  slot the delivered linear belongs to.
REQ-011 i_fill_linear  input  LBW  delivered linear base address.
REQ-012 dst_rdy  output  1  head slot holds a linear.
REQ-013 dst_ack  input  1  consumer takes the head linear.
REQ-014 o_linear  output  LBW  head linear; valid while dst_rdy.
REQ-015 o_count  output  CBW  reserved-and-not-drained slot count.
REQ-016 o_full / o_empty  output  1 each  o_count==DEPTH / o_count==0.
REQ-017 o_err  output  1  sticky protocol-error flag.
REQ-018 blkdone_dval  input  1  block-done flush; present only under the macro in REQ-036.

Function
REQ-019 SHALL hold a write pointer wptr, a read pointer rptr, a filled bit per slot, and an LBW-bit linear per slot.
REQ-020 Slot order SHALL follow reservation order, and delivery order of fills SHALL NOT matter.
REQ-021 alloc_ack SHALL equal alloc_rdy && !o_full, where o_full is evaluated from the current registered count.
REQ-022 o_alloc_tag SHALL equal wptr; on alloc_ack, wptr SHALL advance by 1 and wrap from DEPTH-1 to 0.
REQ-023 On fill_dval, slot i_fill_tag SHALL store i_fill_linear and set its filled bit; the result SHALL be visible to the drain side the next cycle (no bypass).
REQ-024 dst_rdy SHALL equal the filled bit of slot rptr AND !o_empty; o_linear SHALL equal that slot's linear.
REQ-025 On dst_ack, the filled bit of slot rptr SHALL clear and rptr SHALL advance with wrap.
REQ-026 dst_ack without dst_rdy SHALL be ignored and SHALL set o_err.
REQ-027 o_count SHALL increase by 1 on alloc_ack only, decrease by 1 on dst_ack only, and stay unchanged when both occur in the same cycle.
REQ-028 While full, a same-cycle dst_ack SHALL NOT enable alloc_ack; the freed slot is grantable from the next cycle.
REQ-029 A fill to a slot not currently reserved (outside the rptr..wptr-1 window, or o_empty) SHALL be dropped and SHALL set o_err.
REQ-030 A fill to a slot whose filled bit is already set SHALL overwrite the data and SHALL set o_err.
REQ-031 A fill to slot rptr in the same cycle as dst_ack SHALL be treated as the REQ-030 error case, and the slot SHALL end the cycle cleared.
REQ-032 The block SHALL contain no combinational path from alloc_rdy to dst_rdy or from fill_dval to dst_rdy.

Reset
REQ-033 While i_rst=1, wptr, rptr, all filled bits, o_count and o_err SHALL be 0, and stored linears SHALL be 0.
REQ-034 Reset outputs SHALL be: alloc_ack = alloc_rdy, dst_rdy=0, o_linear=0, o_alloc_tag=0, o_empty=1, o_full=0, o_err=0.
REQ-035 Assertion of reset mid-operation SHALL discard all reservations and fills immediately, with no drain of pending linears.

Configuration
REQ-036 Macro LINEAR_ROB_FLUSH_EN SHALL control flush support.
- Defined: the blkdone_dval port exists. When blkdone_dval=1, the next state SHALL equal the reset state except o_err, which is retained. Flush has priority over same-cycle alloc, fill and drain. alloc_ack and dst_rdy SHALL be 0 in a flush cycle.
- Undefined: the port and logic are absent, and behaviour is otherwise identical.

Verification
REQ-037 DEPTH=4: 4 allocs -> tags 0,1,2,3, o_full=1; 5th alloc_rdy -> alloc_ack=0.
REQ-038 Allocs tags 0,1,2; fills tag2=0x30, tag0=0x10, tag1=0x20 on separate cycles -> drain order 0x10, 0x20, 0x30, with dst_rdy rising the cycle after the tag0 fill.
REQ-039 Full (DEPTH=4), head filled, alloc_rdy and dst_ack in the same cycle -> alloc_ack=0, o_count goes 4->3; next cycle alloc_ack=1 with tag 0 after the wrap.
REQ-040 DEPTH=3: 7 alloc/fill/drain rounds -> tags wrap as 0,1,2,0,1,2,0, data is in order, and o_err=0 throughout.
REQ-041 Fill to an unreserved tag while empty -> o_err=1 (sticky), dst_rdy stays 0, o_count=0.
REQ-042 With LINEAR_ROB_FLUSH_EN defined: 2 reserved and 1 filled, then blkdone_dval pulse -> next cycle o_count=0, dst_rdy=0, and the next alloc tag is 0.
